// File: rtl/isqrt_square_check_if.sv
// Request/response bundle for the integer squarer / square-root checker.
interface isqrt_square_check_if #(
    parameter int unsigned WIDTH = 16
);
    logic                   start;
    logic                   flush;
    logic [WIDTH-1:0]       root;
    logic [2*WIDTH-1:0]     radicand;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     square;
    logic [WIDTH:0]         remainder;
    logic                   root_ok;

    // Requester side: drives the operands and the control strobes.
    modport master (
        output start, flush, root, radicand,
        input  busy, done, square, remainder, root_ok
    );

    // Checker side: consumes operands, returns results.
    modport slave (
        input  start, flush, root, radicand,
        output busy, done, square, remainder, root_ok
    );
endinterface

// File: rtl/isqrt_square_check.sv
// Multi-cycle radix-2 squarer that also verifies q == floor(sqrt(a)).
module isqrt_square_check #(
    parameter int unsigned WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    isqrt_square_check_if.slave  bus
);

    localparam int unsigned DW    = 2 * WIDTH;
    localparam int unsigned XW    = DW + 1;
    localparam int unsigned RW    = WIDTH + 1;
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    state_t             state_q, state_d;

    logic [WIDTH-1:0]   q_q, q_d;
    logic [DW-1:0]      a_q, a_d;
    logic [DW-1:0]      acc_q, acc_d;
    logic [DW-1:0]      md_q, md_d;
    logic [WIDTH-1:0]   mr_q, mr_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [DW-1:0]      square_q, square_d;
    logic [RW-1:0]      remainder_q, remainder_d;
    logic               root_ok_q, root_ok_d;

    logic               accept_c;
    logic [XW-1:0]      diff_c;
    logic [XW-1:0]      two_q_c;
    logic               fits_c;

    assign accept_c = bus.start && !bus.flush;

    // Signed difference a - q^2 and the 2q bound, both at 2*WIDTH+1 bits.
    assign diff_c  = {1'b0, a_q} - {1'b0, acc_q};
    assign two_q_c = XW'({q_q, 1'b0});
    assign fits_c  = !diff_c[XW-1] && (diff_c <= two_q_c);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush aborts any in-flight operation.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                if (bus.flush) begin
                    state_d = ST_IDLE;
                end else if (count_q == LAST_ITER) begin
                    state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Datapath and output next values; results only update on an unflushed FIN.
    always_comb begin
        q_d         = q_q;
        a_d         = a_q;
        acc_d       = acc_q;
        md_d        = md_q;
        mr_d        = mr_q;
        count_d     = count_q;
        square_d    = square_q;
        remainder_d = remainder_q;
        root_ok_d   = root_ok_q;
        done_d      = 1'b0;
        busy_d      = (state_d != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    q_d     = bus.root;
                    a_d     = bus.radicand;
                    acc_d   = '0;
                    mr_d    = bus.root;
                    md_d    = DW'(bus.root);
                    count_d = '0;
                end
            end
            ST_CALC: begin
                if (!bus.flush) begin
                    if (mr_q[0]) begin
                        acc_d = acc_q + md_q;
                    end
                    md_d    = md_q << 1;
                    mr_d    = mr_q >> 1;
                    count_d = count_q + CNT_W'(1);
                end
            end
            ST_FIN: begin
                if (!bus.flush) begin
                    square_d    = acc_q;
                    remainder_d = diff_c[RW-1:0];
                    root_ok_d   = fits_c;
                    done_d      = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q         <= '0;
            a_q         <= '0;
            acc_q       <= '0;
            md_q        <= '0;
            mr_q        <= '0;
            count_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            square_q    <= '0;
            remainder_q <= '0;
            root_ok_q   <= 1'b0;
        end else begin
            q_q         <= q_d;
            a_q         <= a_d;
            acc_q       <= acc_d;
            md_q        <= md_d;
            mr_q        <= mr_d;
            count_q     <= count_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            square_q    <= square_d;
            remainder_q <= remainder_d;
            root_ok_q   <= root_ok_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.square    = square_q;
    assign bus.remainder = remainder_q;
    assign bus.root_ok   = root_ok_q;

endmodule

// File: tb/tb_isqrt_square_check.sv
// Directed bench for isqrt_square_check with hand-computed expected values.
module tb_isqrt_square_check;

    localparam int unsigned WIDTH = 16;

    logic clk;
    logic rst;
    int   n_total;
    int   n_bad;

    isqrt_square_check_if #(.WIDTH(WIDTH)) bus_if ();

    isqrt_square_check #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts and reports mismatches.
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request and wait for done; lat counts cycles after the start cycle.
    task automatic do_op(input logic [15:0] q, input logic [31:0] a,
                         output int lat, output int bcnt);
        bus_if.root     = q;
        bus_if.radicand = a;
        bus_if.start    = 1'b1;
        bcnt = 0;
        tick();
        bus_if.start    = 1'b0;
        bus_if.root     = ~q;
        bus_if.radicand = ~a;
        lat = 1;
        while (!bus_if.done && lat < 60) begin
            if (bus_if.busy) bcnt++;
            tick();
            lat++;
        end
    endtask

    task automatic chk_res(input string tag, input logic [31:0] sq,
                           input logic [16:0] rem, input logic ok);
        chk({tag, "_square"}, 64'(bus_if.square), 64'(sq));
        chk({tag, "_rem"}, 64'(bus_if.remainder), 64'(rem));
        chk({tag, "_ok"}, 64'(bus_if.root_ok), 64'(ok));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int bcnt;
        int dones;
        int first_lat;
        int busy_seen;

        n_total = 0;
        n_bad   = 0;
        rst = 1'b1;
        bus_if.start    = 1'b0;
        bus_if.flush    = 1'b0;
        bus_if.root     = '0;
        bus_if.radicand = '0;
        tick();
        tick();

        chk("rst_busy", 64'(bus_if.busy), 64'd0);
        chk("rst_done", 64'(bus_if.done), 64'd0);
        chk("rst_square", 64'(bus_if.square), 64'd0);
        chk("rst_rem", 64'(bus_if.remainder), 64'd0);
        chk("rst_ok", 64'(bus_if.root_ok), 64'd0);
        rst = 1'b0;
        tick();

        // Zero operands: full-length loop, exact latency and busy window.
        do_op(16'd0, 32'd0, lat, bcnt);
        chk("zero_lat", 64'(lat), 64'd18);
        chk("zero_busy", 64'(bcnt), 64'd17);
        chk("zero_busy_in_done", 64'(bus_if.busy), 64'd0);
        chk_res("zero", 32'd0, 17'd0, 1'b1);
        tick();
        chk("done_one_cycle", 64'(bus_if.done), 64'd0);
        chk("hold_ok", 64'(bus_if.root_ok), 64'd1);

        do_op(16'd255, 32'd65535, lat, bcnt);
        chk("q255_lat", 64'(lat), 64'd18);
        chk_res("q255", 32'd65025, 17'd510, 1'b1);

        do_op(16'd256, 32'd65535, lat, bcnt);
        chk_res("q256", 32'd65536, 17'h1FFFF, 1'b0);

        do_op(16'hFFFF, 32'hFFFF_FFFF, lat, bcnt);
        chk_res("qmax", 32'hFFFE_0001, 17'h1FFFE, 1'b1);

        do_op(16'd3, 32'd16, lat, bcnt);
        chk_res("q3", 32'd9, 17'd7, 1'b0);

        // start while busy is ignored.
        bus_if.root     = 16'd10;
        bus_if.radicand = 32'd100;
        bus_if.start    = 1'b1;
        tick();
        bus_if.start = 1'b0;
        dones = 0;
        first_lat = 0;
        for (int c = 1; c <= 40; c++) begin
            if (c == 5) begin
                bus_if.root     = 16'd20;
                bus_if.radicand = 32'd400;
                bus_if.start    = 1'b1;
            end else begin
                bus_if.start = 1'b0;
            end
            if (bus_if.done) begin
                dones++;
                if (first_lat == 0) first_lat = c;
            end
            if (c == 18) chk("ign_square", 64'(bus_if.square), 64'd100);
            tick();
        end
        chk("ign_dones", 64'(dones), 64'd1);
        chk("ign_lat", 64'(first_lat), 64'd18);

        // Back-to-back: new start in the done cycle.
        do_op(16'd10, 32'd100, lat, bcnt);
        chk("b2b_first", 64'(bus_if.square), 64'd100);
        do_op(16'd20, 32'd400, lat, bcnt);
        chk("b2b_lat", 64'(lat), 64'd18);
        chk_res("b2b", 32'd400, 17'd0, 1'b1);

        // Flush mid-CALC: no done, busy drops, outputs kept.
        bus_if.root     = 16'd12;
        bus_if.radicand = 32'd144;
        bus_if.start    = 1'b1;
        tick();
        bus_if.start = 1'b0;
        dones = 0;
        busy_seen = 0;
        for (int c = 1; c <= 30; c++) begin
            bus_if.flush = (c == 8);
            if (c == 9) chk("flush_busy", 64'(bus_if.busy), 64'd0);
            if (c >= 9 && bus_if.busy) busy_seen++;
            if (bus_if.done) dones++;
            tick();
        end
        bus_if.flush = 1'b0;
        chk("flush_dones", 64'(dones), 64'd0);
        chk("flush_busy_after", 64'(busy_seen), 64'd0);
        chk_res("flush_hold", 32'd400, 17'd0, 1'b1);

        do_op(16'd12, 32'd144, lat, bcnt);
        chk("after_flush_lat", 64'(lat), 64'd18);
        chk_res("after_flush", 32'd144, 17'd0, 1'b1);

        // flush together with start in IDLE: start ignored.
        bus_if.start = 1'b1;
        bus_if.flush = 1'b1;
        tick();
        bus_if.start = 1'b0;
        bus_if.flush = 1'b0;
        chk("flush_start_busy", 64'(bus_if.busy), 64'd0);

        // Reset mid-CALC with start held.
        bus_if.root     = 16'd5;
        bus_if.radicand = 32'd30;
        bus_if.start    = 1'b1;
        tick();
        bus_if.start = 1'b0;
        repeat (5) tick();
        chk("pre_rst_busy", 64'(bus_if.busy), 64'd1);
        rst = 1'b1;
        bus_if.start = 1'b1;
        tick();
        chk("mid_rst_busy", 64'(bus_if.busy), 64'd0);
        chk("mid_rst_done", 64'(bus_if.done), 64'd0);
        chk_res("mid_rst", 32'd0, 17'd0, 1'b0);
        tick();
        rst = 1'b0;
        bus_if.start = 1'b0;
        dones = 0;
        busy_seen = 0;
        for (int c = 0; c < 25; c++) begin
            tick();
            if (bus_if.done) dones++;
            if (bus_if.busy) busy_seen++;
        end
        chk("rst_start_ignored_done", 64'(dones), 64'd0);
        chk("rst_start_ignored_busy", 64'(busy_seen), 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
